// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the DataMemory arbiter.
//   arb_state_e          - arbiter FSM states
//   PORT_CPU / PORT_AUX  - grant_id encodings for port 0 / port 1
//   STARVE_LIMIT_DEFAULT - default lost-arbitration limit for port 1
//   STARVE_CNT_W         - starvation counter width (covers limits 1..15)
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ACK
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned STARVE_CNT_W         = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester-side DataMemory access port.
//   req   - access request, held until ack
//   we    - 1=write, 0=read
//   addr  - word address
//   wdata - write data
//   ack   - one-cycle completion pulse
//   rdata - read data, valid while ack=1
// Modports: master (requester), slave (arbiter).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: saturating count of consecutive port-1 lost arbitrations.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - clear to zero (takes precedence over inc)
//   inc        - increment by one, saturating at LIMIT
//   cnt        - current count
//   at_limit   - cnt == LIMIT
// With neither clr nor inc the count holds.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    inc,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LimitV = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !at_limit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_limit = (cnt_q == LimitV);
    assign cnt      = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DataMemory between port 0 (CPU MEM stage)
// and port 1 (loader/debug). Port 0 has fixed priority; port 1 wins outright
// after STARVE_LIMIT consecutive losses.
//   clk, rst_n - clock, asynchronous active-low reset
//   p0, p1     - requester ports (dmem_arbiter_if slave)
//   mem_read, mem_write, mem_addr, mem_wdata - to DataMemory, driven in IDLE
//   mem_rdata  - from DataMemory (combinational read)
//   grant_id   - port served in the current ACK cycle
//   busy       - 1 while in ACK
// One access every two cycles: IDLE drives the memory, ACK returns the
// registered result.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_id,
    output logic              busy
);

    arb_state_e              state_q;
    logic                    p0_ack_q, p1_ack_q;
    logic [DATA_W-1:0]       p0_rdata_q, p1_rdata_q;
    logic                    grant_q, busy_q;

    logic                    in_idle, any_req, p1_wins, at_limit;
    logic                    starve_clr, starve_inc;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    assign in_idle = (state_q == ST_IDLE);
    assign any_req = p0.req || p1.req;
    assign p1_wins = p1.req && (at_limit || !p0.req);

    // Counter only moves in IDLE; ACK holds it.
    assign starve_clr = in_idle && (p1_wins || !p1.req);
    assign starve_inc = in_idle && p1.req && !p1_wins;

    dmem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (starve_clr),
        .inc      (starve_inc),
        .cnt      (starve_cnt),
        .at_limit (at_limit)
    );

    // Memory side is zero whenever nothing is being granted.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_idle && any_req) begin
            if (p1_wins) begin
                mem_addr  = p1.addr;
                mem_wdata = p1.wdata;
                mem_write = p1.we;
                mem_read  = !p1.we;
            end else begin
                mem_addr  = p0.addr;
                mem_wdata = p0.wdata;
                mem_write = p0.we;
                mem_read  = !p0.we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            grant_q    <= PORT_CPU;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_ACK;
                        busy_q  <= 1'b1;
                        if (p1_wins) begin
                            grant_q  <= PORT_AUX;
                            p1_ack_q <= 1'b1;
                            if (!p1.we) p1_rdata_q <= mem_rdata;
                        end else begin
                            grant_q  <= PORT_CPU;
                            p0_ack_q <= 1'b1;
                            if (!p0.we) p0_rdata_q <= mem_rdata;
                        end
                    end
                end
                ST_ACK: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign p0.ack   = p0_ack_q;
    assign p1.ack   = p1_ack_q;
    assign p0.rdata = p0_rdata_q;
    assign p1.rdata = p1_rdata_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter against a behavioural
// 1024-word DataMemory (combinational read, write at clock edge).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant_id, busy;

    logic [31:0] dmem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_bus ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_bus ();

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_bus.slave),
        .p1        (p1_bus.slave),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
        end else begin
            p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
        end
    endtask

    logic       exp_grant [6];
    logic [3:0] exp_cnt   [6];

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = 32'(i);
        dmem[2] = 32'd3;
        dmem[4] = 32'd5;
        dmem[7] = 32'd9;

        exp_grant[0] = 1'b0; exp_cnt[0] = 4'd1;
        exp_grant[1] = 1'b0; exp_cnt[1] = 4'd2;
        exp_grant[2] = 1'b0; exp_cnt[2] = 4'd3;
        exp_grant[3] = 1'b0; exp_cnt[3] = 4'd4;
        exp_grant[4] = 1'b1; exp_cnt[4] = 4'd0;
        exp_grant[5] = 1'b0; exp_cnt[5] = 4'd1;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_eq("rst p0_ack", 64'(p0_bus.ack), 64'd0);
        check_eq("rst p1_ack", 64'(p1_bus.ack), 64'd0);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst grant_id", 64'(grant_id), 64'd0);
        check_eq("rst p0_rdata", 64'(p0_bus.rdata), 64'd0);
        check_eq("rst mem_rw", 64'({mem_read, mem_write}), 64'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single read
        drive(1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
        #1;
        check_eq("rd mem_read", 64'(mem_read), 64'd1);
        check_eq("rd mem_addr", 64'(mem_addr), 64'd2);
        tick();
        check_eq("rd p0_ack", 64'(p0_bus.ack), 64'd1);
        check_eq("rd p0_rdata", 64'(p0_bus.rdata), 64'd3);
        check_eq("rd p1_ack", 64'(p1_bus.ack), 64'd0);
        check_eq("rd busy", 64'(busy), 64'd1);
        check_eq("rd grant", 64'(grant_id), 64'(PORT_CPU));
        check_eq("rd mem_read in ack", 64'(mem_read), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check_eq("rd ack drop", 64'({p0_bus.ack, p1_bus.ack, busy}), 64'd0);

        // Port 1 write then read
        drive(1'b1, 1'b1, 1'b1, 32'd10, 32'hDEADBEEF);
        #1;
        check_eq("wr mem_write", 64'(mem_write), 64'd1);
        check_eq("wr mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        tick();
        check_eq("wr p1_ack", 64'(p1_bus.ack), 64'd1);
        check_eq("wr grant", 64'(grant_id), 64'(PORT_AUX));
        check_eq("wr mem_write in ack", 64'(mem_write), 64'd0);
        check_eq("wr p1_rdata held", 64'(p1_bus.rdata), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd10, 32'd0);
        tick();
        check_eq("wr-rd p1_ack", 64'(p1_bus.ack), 64'd1);
        check_eq("wr-rd p1_rdata", 64'(p1_bus.rdata), 64'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Contention: p0 first, p1 two cycles later
        drive(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd0);
        #1;
        check_eq("cont mem_addr p0", 64'(mem_addr), 64'd4);
        tick();
        check_eq("cont p0_ack", 64'(p0_bus.ack), 64'd1);
        check_eq("cont p0_rdata", 64'(p0_bus.rdata), 64'd5);
        check_eq("cont p1_ack early", 64'(p1_bus.ack), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check_eq("cont mem_addr p1", 64'(mem_addr), 64'd7);
        tick();
        check_eq("cont p1_ack", 64'(p1_bus.ack), 64'd1);
        check_eq("cont p1_rdata", 64'(p1_bus.rdata), 64'd9);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Starvation: both held high; p1 wins the 5th arbitration
        drive(1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd8, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("starve grant %0d", k), 64'(grant_id), 64'(exp_grant[k]));
            check_eq($sformatf("starve cnt %0d", k), 64'(dut.u_starve.cnt_q), 64'(exp_cnt[k]));
            check_eq($sformatf("starve ack %0d", k), 64'({p1_bus.ack, p0_bus.ack}),
                     exp_grant[k] ? 64'd2 : 64'd1);
            tick();
        end
        check_eq("starve p1_rdata", 64'(p1_bus.rdata), 64'd8);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Reset during ACK
        drive(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
        tick();
        check_eq("rstack p0_ack before", 64'(p0_bus.ack), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstack p0_ack", 64'(p0_bus.ack), 64'd0);
        check_eq("rstack busy", 64'(busy), 64'd0);
        check_eq("rstack p0_rdata", 64'(p0_bus.rdata), 64'd0);
        check_eq("rstack p1_rdata", 64'(p1_bus.rdata), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd8, 32'd0);
        tick();
        check_eq("rstack reread ack", 64'(p0_bus.ack), 64'd1);
        check_eq("rstack reread data", 64'(p0_bus.rdata), 64'd8);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Idle hold
        for (int c = 0; c < 20; c++) begin
            check_eq($sformatf("idle outs %0d", c),
                     64'({mem_read, mem_write, p0_bus.ack, p1_bus.ack, busy}), 64'd0);
            tick();
        end
        check_eq("idle mem_addr", 64'(mem_addr), 64'd0);
        check_eq("idle p0_rdata", 64'(p0_bus.rdata), 64'd8);
        check_eq("idle p1_rdata", 64'(p1_bus.rdata), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DataMemory between two requesters: port 0 (CPU MEM stage) and port 1 (loader/debug port).
- Fixed priority to port 0, with a starvation guard that forces a port-1 grant after STARVE_LIMIT consecutive lost arbitrations.
- Sits between the pipeline/debug logic and DataMemory, and drives its memRead/memWrite/address/writeData.
- Returns registered read data with a one-cycle ack.

Parameters:
- ADDR_W, 32, address width of both ports and the memory side.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive port-1 losses after which port 1 wins unconditionally (legal range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 access request, held until p0_ack.
- p0_we  in  1  port 0: 1=write, 0=read.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle pulse: port 0 access complete.
- p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack=1.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- mem_read  out  1  to DataMemory memRead.
- mem_write  out  1  to DataMemory memWrite.
- mem_addr  out  ADDR_W  to DataMemory address.
- mem_wdata  out  DATA_W  to DataMemory writeData.
- mem_rdata  in  DATA_W  from DataMemory readData (combinational read).
- grant_id  out  1  port granted in the current cycle; meaningful only while busy=1.
- busy  out  1  1 while in the ACK state.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - state=IDLE; p0_ack=p1_ack=0; p0_rdata=p1_rdata=0; starve_cnt=0; grant_id=0; busy=0.
  - mem_read=mem_write=0.
- FSM has two states, IDLE and ACK.
- IDLE with no request: outputs are zero and the FSM stays in IDLE.
- IDLE with one or both requests pending:
  - Winner is p1 if p1_req and (starve_cnt==STARVE_LIMIT or !p0_req); otherwise p0.
  - In the same cycle, drive mem_addr/mem_wdata from the winner. mem_write=winner_we; mem_read=!winner_we.
  - At the next edge: capture mem_rdata into the winner's rdata register (hold the old value on writes); set the winner's ack; set grant_id; state becomes ACK.
- ACK state (exactly one cycle):
  - Winner's ack=1 and busy=1. mem_read=mem_write=0.
  - All req inputs are ignored.
  - Next state is IDLE and both acks clear.
- Requester rule: drop req in the ack cycle. A req still high in the following IDLE cycle is a new access.
- Throughput: one access per 2 cycles. Read latency is request accepted in cycle N, data and ack in cycle N+1.
- Write commit: DataMemory writes at the end of cycle N, so a read granted at the next IDLE sees the new value.
- starve_cnt (updated in IDLE only):
  - Increments by 1 when p1_req=1 and p0 wins, saturating at STARVE_LIMIT.
  - Clears when p1 wins or p1_req=0.
  - Holds during ACK.
- Simultaneous requests on the same address: serialised in winner order. No forwarding between ports.
- Address is passed through unmodified; DataMemory uses the low 10 bits. No width conversion.
- Reset mid-ACK: ack drops asynchronously. A write issued in the previous IDLE cycle has already committed. A read is lost and the requester must reissue.
- Unused rdata: the non-winning port's rdata holds its previous value.
- No X propagation: with no winner, all mem_* outputs are driven 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum {ST_IDLE, ST_ACK};
  - port-id constants PORT_CPU=1'b0 and PORT_AUX=1'b1;
  - the default STARVE_LIMIT.
- One natural sub-module, dmem_arb_starve_cnt: the saturating counter with clear/increment/hold inputs and an at_limit output.
- Winner select, the FSM and the rdata registers stay in dmem_arbiter.

Test Plan:
- Single read: after reset, p0 reads addr 2 with DataMemory word 2 = 3 → p0_ack pulses 1 cycle later with p0_rdata=3, mem_read high for exactly 1 cycle, p1_ack never asserted.
- Write then read: p1 writes 0xDEADBEEF to addr 10, then p1 reads addr 10 → second ack returns 0xDEADBEEF, with mem_write high exactly 1 cycle.
- Contention: p0 and p1 request on the same cycle (p0 reads addr 4=5, p1 reads addr 7=9) → p0 is acked first with 5, p1 two cycles later with 9.
- Starvation (STARVE_LIMIT=4): p0 holds req continuously (reissuing after every ack) while p1 requests → p1 is granted at the 5th arbitration, starve_cnt returns to 0, and p0 resumes.
- Reset mid-ACK: assert rst_n=0 during an ack cycle → ack and busy go 0 immediately; after release, state=IDLE, rdata=0, and a new p0 read of addr 8 returns 8.
- Idle/hold: hold both reqs low for 20 cycles → mem_read, mem_write, ack and busy stay 0, and rdata registers keep their last values.
